// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// State | meaning: IDLE = accept request, EXEC = ALU computing, RESP = result held for winner.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_rslt,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_rslt,
    output logic              rsp1_zero,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [WIDTH-1:0]  alu_in2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_rslt,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic [CTRL_W-1:0]   opc_q, opc_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic                resz_q, resz_d;
    logic                gid_q, gid_d;
    logic                last_q, last_d;
    logic                grant0, grant1;
    logic                rsp_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            res_q   <= '0;
            resz_q  <= 1'b0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            res_q   <= res_d;
            resz_q  <= resz_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
        end
    end

    // On a tie the requester that did not win last time gets the grant.
    assign grant0 = req0_valid & (~req1_valid | last_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_q);
    assign rsp_take = gid_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        opc_d      = opc_q;
        res_d      = res_q;
        resz_d     = resz_q;
        gid_d      = gid_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0) begin
                    opa_d   = req0_a;
                    opb_d   = req0_b;
                    opc_d   = req0_op;
                    gid_d   = 1'b0;
                    state_d = S_EXEC;
                end else if (grant1) begin
                    opa_d   = req1_a;
                    opb_d   = req1_b;
                    opc_d   = req1_op;
                    gid_d   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_rslt;
                resz_d  = alu_zero;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_take) begin
                    last_d  = gid_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign alu_in1    = opa_q;
    assign alu_in2    = opb_q;
    assign alu_ctrl   = opc_q;
    assign rsp0_valid = (state_q == S_RESP) & ~gid_q;
    assign rsp1_valid = (state_q == S_RESP) & gid_q;
    assign rsp0_rslt  = res_q;
    assign rsp1_rslt  = res_q;
    assign rsp0_zero  = resz_q;
    assign rsp1_zero  = resz_q;
    assign busy       = (state_q != S_IDLE);

endmodule
